// File: rtl/immediate_17_splitter.sv
// Splits 32-bit constants into 17-bit immediate beats: one FULL beat when the value
// sign-extends from 17 bits, otherwise a HI/LO pair. Valid/ready on both sides.
module immediate_17_splitter #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter bit          FORCE_SPLIT = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16:0]          out_imm,
  output logic [1:0]           out_kind,
  output logic                 out_last,
  output logic [CNT_WIDTH-1:0] split_count
);

  localparam logic [1:0] KindFull = 2'd0;
  localparam logic [1:0] KindHi   = 2'd1;
  localparam logic [1:0] KindLo   = 2'd2;

  typedef enum logic [1:0] {StIdle, StEmitFull, StEmitHi, StEmitLo} state_e;

  state_e                 state_q;
  logic [31:0]            hold_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [16:0]            out_imm_q;
  logic [1:0]             out_kind_q;
  logic                   out_last_q;
  logic [CNT_WIDTH-1:0]   split_count_q;
  logic [CNT_WIDTH-1:0]   split_count_d;
  logic                   fits;
  logic                   accept;

  always_comb begin
    fits          = (in_data[31:17] == {15{in_data[16]}}) & ~FORCE_SPLIT;
    accept        = in_valid & in_ready_q;
    split_count_d = (&split_count_q) ? split_count_q : split_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_kind_q    <= KindFull;
      out_last_q    <= 1'b0;
      split_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            hold_q      <= in_data;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            if (fits) begin
              state_q    <= StEmitFull;
              out_imm_q  <= in_data[16:0];
              out_kind_q <= KindFull;
              out_last_q <= 1'b1;
            end else begin
              state_q       <= StEmitHi;
              out_imm_q     <= {1'b0, in_data[31:16]};
              out_kind_q    <= KindHi;
              out_last_q    <= 1'b0;
              split_count_q <= split_count_d;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        StEmitFull: begin
          if (out_ready) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_kind_q  <= KindFull;
            out_last_q  <= 1'b0;
          end else begin
            // Refresh from hold_q; the value is identical while stalled.
            out_imm_q <= hold_q[16:0];
          end
        end
        StEmitHi: begin
          if (out_ready) begin
            state_q    <= StEmitLo;
            out_imm_q  <= {1'b0, hold_q[15:0]};
            out_kind_q <= KindLo;
            out_last_q <= 1'b1;
          end else begin
            out_imm_q <= {1'b0, hold_q[31:16]};
          end
        end
        StEmitLo: begin
          if (out_ready) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_kind_q  <= KindFull;
            out_last_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_kind    = out_kind_q;
  assign out_last    = out_last_q;
  assign split_count = split_count_q;

endmodule

// File: tb/tb_immediate_17_splitter.sv
// Scoreboard bench for immediate_17_splitter: default, FORCE_SPLIT=1 and CNT_WIDTH=2 instances.
module tb_immediate_17_splitter;

  typedef struct packed {
    logic [16:0] imm;
    logic [1:0]  kind;
    logic        last;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Main instance
  logic        iv_m = 1'b0, ordy_m = 1'b1, irdy_m, ov_m, last_m;
  logic [31:0] id_m = '0;
  logic [16:0] imm_m;
  logic [1:0]  kind_m;
  logic [15:0] cnt_m;
  // FORCE_SPLIT instance
  logic        iv_f = 1'b0, ordy_f = 1'b1, irdy_f, ov_f, last_f;
  logic [31:0] id_f = '0;
  logic [16:0] imm_f;
  logic [1:0]  kind_f;
  logic [15:0] cnt_f;
  // Narrow-counter instance
  logic        iv_s = 1'b0, ordy_s = 1'b1, irdy_s, ov_s, last_s;
  logic [31:0] id_s = '0;
  logic [16:0] imm_s;
  logic [1:0]  kind_s;
  logic [1:0]  cnt_s;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  beat_t exp_f[$];
  beat_t mon_b;

  immediate_17_splitter dut_m (
    .clock(clock), .reset(reset), .in_valid(iv_m), .in_ready(irdy_m), .in_data(id_m),
    .out_valid(ov_m), .out_ready(ordy_m), .out_imm(imm_m), .out_kind(kind_m),
    .out_last(last_m), .split_count(cnt_m)
  );

  immediate_17_splitter #(.FORCE_SPLIT(1'b1)) dut_f (
    .clock(clock), .reset(reset), .in_valid(iv_f), .in_ready(irdy_f), .in_data(id_f),
    .out_valid(ov_f), .out_ready(ordy_f), .out_imm(imm_f), .out_kind(kind_f),
    .out_last(last_f), .split_count(cnt_f)
  );

  immediate_17_splitter #(.CNT_WIDTH(2)) dut_s (
    .clock(clock), .reset(reset), .in_valid(iv_s), .in_ready(irdy_s), .in_data(id_s),
    .out_valid(ov_s), .out_ready(ordy_s), .out_imm(imm_s), .out_kind(kind_s),
    .out_last(last_s), .split_count(cnt_s)
  );

  function automatic beat_t mk(input logic [16:0] imm, input logic [1:0] kind, input logic last);
    beat_t b;
    b.imm  = imm;
    b.kind = kind;
    b.last = last;
    return b;
  endfunction

  // Scoreboard for the main instance: every completed beat must match the queue head.
  always @(negedge clock) begin
    if (reset && ov_m && ordy_m) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stray_beat: got imm=%h kind=%0d last=%0b, expected no beat",
                 imm_m, kind_m, last_m);
      end else begin
        mon_b = exp_q.pop_front();
        if ({imm_m, kind_m, last_m} !== mon_b) begin
          n_fail++;
          $display("FAIL beat: got imm=%h kind=%0d last=%0b, expected imm=%h kind=%0d last=%0b",
                   imm_m, kind_m, last_m, mon_b.imm, mon_b.kind, mon_b.last);
        end
      end
    end
  end

  task automatic send_m(input logic [31:0] d);
    int n = 0;
    @(negedge clock);
    while (!irdy_m && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!irdy_m) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_ready_timeout: in_ready=%0b, expected 1", irdy_m);
    end
    iv_m = 1'b1;
    id_m = d;
    @(posedge clock);
    #1 iv_m = 1'b0;
  endtask

  task automatic wait_drain_m();
    int n = 0;
    while ((exp_q.size() != 0 || ov_m) && n < 30) begin
      @(negedge clock);
      #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || ov_m) begin
      n_fail++;
      $display("FAIL drain: %0d beats pending, out_valid=%0b, expected 0 and 0", exp_q.size(), ov_m);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({ov_m, imm_m, kind_m, last_m, irdy_m, cnt_m} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got valid=%0b imm=%h kind=%0d last=%0b ready=%0b cnt=%0d, expected 0",
               ov_m, imm_m, kind_m, last_m, irdy_m, cnt_m);
    end
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (irdy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready=%0b, expected 1", irdy_m);
    end
    // Stall mid-HI, then reset asynchronously.
    ordy_m = 1'b0;
    send_m(32'h0002_0000);
    @(negedge clock);
    n_checks++;
    if (ov_m !== 1'b1 || kind_m !== 2'd1 || cnt_m !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_pre_hi: got valid=%0b kind=%0d cnt=%0d, expected 1 1 1",
               ov_m, kind_m, cnt_m);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({ov_m, imm_m, kind_m, last_m, irdy_m, cnt_m} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%0b imm=%h kind=%0d last=%0b ready=%0b cnt=%0d, expected 0",
               ov_m, imm_m, kind_m, last_m, irdy_m, cnt_m);
    end
    @(negedge clock) reset = 1'b1;
    ordy_m = 1'b1;
    repeat (4) begin
      @(negedge clock);
      n_checks++;
      if (ov_m !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_stray: got out_valid=%0b, expected 0", ov_m);
      end
    end
    n_checks++;
    if (irdy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got in_ready=%0b, expected 1", irdy_m);
    end
  endtask

  task automatic test_fit_single();
    exp_q.push_back(mk(17'h01234, 2'd0, 1'b1));
    send_m(32'h0000_1234);
    @(negedge clock);
    n_checks++;
    if (ov_m !== 1'b1) begin
      n_fail++;
      $display("FAIL fit_latency: got out_valid=%0b one cycle after accept, expected 1", ov_m);
    end
    wait_drain_m();
    n_checks++;
    if (cnt_m !== 16'd0) begin
      n_fail++;
      $display("FAIL fit_count: got split_count=%0d, expected 0", cnt_m);
    end
  endtask

  task automatic test_negative_fit();
    exp_q.push_back(mk(17'h18000, 2'd0, 1'b1));
    send_m(32'hFFFF_8000);
    exp_q.push_back(mk(17'h10000, 2'd0, 1'b1));
    send_m(32'hFFFF_0000);
    wait_drain_m();
  endtask

  task automatic test_split();
    exp_q.push_back(mk(17'h00001, 2'd1, 1'b0));
    exp_q.push_back(mk(17'h00000, 2'd2, 1'b1));
    send_m(32'h0001_0000);
    wait_drain_m();
    n_checks++;
    if (cnt_m !== 16'd1) begin
      n_fail++;
      $display("FAIL split_count_1: got split_count=%0d, expected 1", cnt_m);
    end
    exp_q.push_back(mk(17'h0DEAD, 2'd1, 1'b0));
    exp_q.push_back(mk(17'h0BEEF, 2'd2, 1'b1));
    send_m(32'hDEAD_BEEF);
    wait_drain_m();
    n_checks++;
    if (cnt_m !== 16'd2) begin
      n_fail++;
      $display("FAIL split_count_2: got split_count=%0d, expected 2", cnt_m);
    end
  endtask

  task automatic test_backpressure();
    ordy_m = 1'b0;
    exp_q.push_back(mk(17'h01234, 2'd1, 1'b0));
    exp_q.push_back(mk(17'h05678, 2'd2, 1'b1));
    send_m(32'h1234_5678);
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if ({ov_m, imm_m, kind_m, last_m, irdy_m} !== {1'b1, 17'h01234, 2'd1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hi_hold: got valid=%0b imm=%h kind=%0d last=%0b ready=%0b, expected 1 01234 1 0 0",
                 ov_m, imm_m, kind_m, last_m, irdy_m);
      end
    end
    @(posedge clock);
    #1 ordy_m = 1'b1;
    @(posedge clock);
    #1 ordy_m = 1'b0;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if ({ov_m, imm_m, kind_m, last_m, irdy_m} !== {1'b1, 17'h05678, 2'd2, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_lo_hold: got valid=%0b imm=%h kind=%0d last=%0b ready=%0b, expected 1 05678 2 1 0",
                 ov_m, imm_m, kind_m, last_m, irdy_m);
      end
    end
    ordy_m = 1'b1;
    wait_drain_m();
    n_checks++;
    if (irdy_m !== 1'b1 || cnt_m !== 16'd3) begin
      n_fail++;
      $display("FAIL bp_after: got in_ready=%0b split_count=%0d, expected 1 and 3", irdy_m, cnt_m);
    end
  endtask

  task automatic test_boundaries();
    exp_q.push_back(mk(17'h0FFFF, 2'd0, 1'b1));
    send_m(32'h0000_FFFF);
    exp_q.push_back(mk(17'h00001, 2'd1, 1'b0));
    exp_q.push_back(mk(17'h00000, 2'd2, 1'b1));
    send_m(32'h0001_0000);
    exp_q.push_back(mk(17'h10000, 2'd0, 1'b1));
    send_m(32'hFFFF_0000);
    exp_q.push_back(mk(17'h0FFFE, 2'd1, 1'b0));
    exp_q.push_back(mk(17'h0FFFF, 2'd2, 1'b1));
    send_m(32'hFFFE_FFFF);
    wait_drain_m();
    n_checks++;
    if (cnt_m !== 16'd5) begin
      n_fail++;
      $display("FAIL boundary_count: got split_count=%0d, expected 5", cnt_m);
    end
  endtask

  task automatic test_force_split();
    int n = 0;
    exp_f.push_back(mk(17'h00000, 2'd1, 1'b0));
    exp_f.push_back(mk(17'h00005, 2'd2, 1'b1));
    @(negedge clock);
    while (!irdy_f && n < 20) begin
      @(negedge clock);
      n++;
    end
    iv_f = 1'b1;
    id_f = 32'h0000_0005;
    @(posedge clock);
    #1 iv_f = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      @(negedge clock);
      while (!ov_f && n < 10) begin
        @(negedge clock);
        n++;
      end
      mon_b = exp_f.pop_front();
      n_checks++;
      if ({ov_f, imm_f, kind_f, last_f} !== {1'b1, mon_b}) begin
        n_fail++;
        $display("FAIL force_split_beat%0d: got valid=%0b imm=%h kind=%0d last=%0b, expected imm=%h kind=%0d last=%0b",
                 k, ov_f, imm_f, kind_f, last_f, mon_b.imm, mon_b.kind, mon_b.last);
      end
    end
    @(negedge clock);
    n_checks++;
    if (ov_f !== 1'b0 || cnt_f !== 16'd1) begin
      n_fail++;
      $display("FAIL force_split_end: got valid=%0b split_count=%0d, expected 0 and 1", ov_f, cnt_f);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      @(negedge clock);
      while (!irdy_s && n < 20) begin
        @(negedge clock);
        n++;
      end
      iv_s = 1'b1;
      id_s = 32'h0001_0000 + 32'(i);
      @(posedge clock);
      #1 iv_s = 1'b0;
      repeat (3) @(negedge clock);
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_checks++;
      if (cnt_s !== want || ov_s !== 1'b0) begin
        n_fail++;
        $display("FAIL saturation_%0d: got split_count=%0d valid=%0b, expected %0d and 0",
                 i, cnt_s, ov_s, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fit_single();
    test_negative_fit();
    test_split();
    test_backpressure();
    test_boundaries();
    test_force_split();
    test_saturation();
    repeat (2) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected beats never seen, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/immediate_17_splitter.md
Name: immediate_17_splitter

Overview:
- Encode-direction counterpart to the 17-bit immediate sign-extension path: converts 32-bit constants into immediate-field beats the 17-bit-immediate ISA can carry.
- Sits between the constant/literal source (assembler-in-hardware, program loader, test generator) and the instruction builder.
- Constants representable as signed 17-bit go out as one beat. All others go out as a HI/LO beat pair. Valid/ready handshakes on both sides.

Parameters:
- CNT_WIDTH, 16, width of saturating split-event counter.
- FORCE_SPLIT, 0, when 1 every constant is emitted as a HI/LO pair, even if it fits.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; asserting low clears all state immediately.
- in_valid  input  1  source presents in_data.
- in_ready  output  1  block can accept a constant this cycle.
- in_data  input  32  constant to encode.
- out_valid  output  1  out_imm/out_kind valid.
- out_ready  input  1  consumer accepts the current beat.
- out_imm  output  17  immediate field.
- out_kind  output  2  0=FULL (sign-extends to the constant), 1=HI, 2=LO; 3 never driven.
- out_last  output  1  high on the final beat of a constant (FULL or LO).
- split_count  output  CNT_WIDTH  number of constants emitted as HI/LO pairs, saturating.

Behaviour:
- State machine: IDLE, EMIT_FULL, EMIT_HI, EMIT_LO. Holding register hold_q[31:0].
- Reset (reset low, asynchronous) forces:
  - state=IDLE, hold_q=0, split_count=0.
  - out_valid=0, out_imm=0, out_kind=0, out_last=0, in_ready=0 while reset is low.
- After reset deasserts, in_ready=1 in IDLE.
- in_ready is high only in IDLE. No input is accepted while a constant is in flight. No combinational path from out_ready to in_ready.
- Accept = in_valid & in_ready. On accept, capture in_data into hold_q and evaluate the fit rule.
- Fit rule: fits = (in_data[31:17] all equal to in_data[16]) & ~FORCE_SPLIT.
  - fits → EMIT_FULL.
  - else → EMIT_HI, and split_count increments by 1, saturating at all-ones.
- Latency: accept on edge t; first beat has out_valid=1 from the cycle after edge t. Outputs are registered.
- EMIT_FULL:
  - out_imm=hold_q[16:0], out_kind=0, out_last=1.
  - On out_ready → IDLE.
- EMIT_HI:
  - out_imm={1'b0, hold_q[31:16]}, out_kind=1, out_last=0.
  - On out_ready → EMIT_LO.
- EMIT_LO:
  - out_imm={1'b0, hold_q[15:0]}, out_kind=2, out_last=1.
  - On out_ready → IDLE.
- Consumer reconstruction contract:
  - FULL: sign-extend to 32 bits.
  - Pair: (HI[15:0] << 16) | LO[15:0].
- Backpressure: while out_valid & ~out_ready, out_imm/out_kind/out_last are held stable and the state does not change.
- Beat completes on out_valid & out_ready. After the last beat, out_valid=0 and in_ready=1 for at least one cycle. Throughput is 1 constant per 2 cycles for FULL, 1 per 3 cycles for pairs.
- Boundaries:
  - 0x0000FFFF (bit16=0, upper bits 0) fits.
  - 0x00010000 does not fit (bit16=1, upper bits 0).
  - 0xFFFF0000 fits (imm=0x10000).
  - 0xFFFEFFFF does not fit.
  - Most-negative fitting value is 0xFFFF0000; most-positive is 0x0000FFFF.
- Reset mid-operation (any state): in-flight constant discarded, no partial beat emitted after reset release.
- in_valid low in IDLE: state unchanged, no counter change.

Test Plan:
- Reset: hold reset low mid-EMIT_HI with out_ready=0 → outputs immediately 0, split_count=0; after release in_ready=1, no stray beat.
- Fit single: in_data=0x00001234 → one beat, out_imm=0x01234, kind=0, last=1, one cycle after accept; split_count unchanged.
- Negative fit: in_data=0xFFFF8000 → out_imm=0x18000, kind=0; in_data=0xFFFF0000 → out_imm=0x10000, kind=0.
- Split: in_data=0x00010000 → HI 0x00001 (kind=1, last=0), then LO 0x00000 (kind=2, last=1); split_count=1.
- Split: in_data=0xDEADBEEF → HI 0x0DEAD, then LO 0x0BEEF.
- Backpressure: in_data=0x12345678 with out_ready low 3 cycles on each beat → HI 0x01234 held stable, then LO 0x05678 held stable; in_ready=0 throughout, then 1.
- FORCE_SPLIT=1: in_data=0x00000005 → HI 0x00000, LO 0x00005.
- CNT_WIDTH=2: 5 splitting constants → split_count saturates at 3.
